// File: rtl/ysyx_210247_mmio_router.sv
// Data-side address router: CLINT register accesses complete locally in one cycle,
// everything else is forwarded to the external bus as a single outstanding request.
module ysyx_210247_mmio_router #(
  parameter logic [63:0] CLINT_BASE    = 64'h0000_0000_0200_0000,
  parameter logic [63:0] CLINT_MASK    = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic        mem_resp_valid,
  output logic [63:0] mem_rdata,
  output logic        cmp_ren,
  output logic [63:0] cmp_addr,
  output logic        cmp_wen,
  output logic [63:0] cmp_wdata,
  input  logic [63:0] cmp_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic        bus_wen,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLINT_RESP,
    S_BUS_REQ,
    S_BUS_WAIT
  } state_t;

  state_t      r_state;
  logic [63:0] r_resp;
  logic [63:0] r_bus_addr;
  logic [63:0] r_bus_wdata;
  logic        r_bus_wen;
  logic [7:0]  r_bus_wstrb;

  logic        w_idle;
  logic        w_hs;
  logic        w_clint_hit;
  logic        w_cmp_hs;
  logic        w_cmp_wr;
  logic        w_clint_resp;
  logic        w_bus_resp;
  logic [63:0] w_aligned;
  logic [63:0] w_merged;

  // Outputs are gated by rst so the reset cycle itself shows reset values.
  assign w_idle       = (r_state == S_IDLE) && !rst;
  assign w_hs         = w_idle && mem_req_valid;
  assign w_aligned    = {mem_addr[63:3], 3'b000};
  assign w_clint_hit  = (mem_addr & CLINT_MASK) == CLINT_BASE;
  assign w_cmp_hs     = w_hs && w_clint_hit;
  assign w_cmp_wr     = w_cmp_hs && mem_wen && (w_aligned == MTIMECMP_ADDR);
  assign w_clint_resp = (r_state == S_CLINT_RESP) && !rst;
  assign w_bus_resp   = (r_state == S_BUS_WAIT) && bus_resp_valid && !rst;

  // Byte-lane read-modify-write of mtimecmp using the combinational CLINT read.
  always_comb begin
    w_merged = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_merged[8*i +: 8] = mem_wstrb[i] ? mem_wdata[8*i +: 8] : cmp_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_resp      <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wen   <= 1'b0;
      r_bus_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            if (w_clint_hit) begin
              r_resp  <= mem_wen ? '0 : cmp_rdata;
              r_state <= S_CLINT_RESP;
            end else begin
              r_bus_addr  <= mem_addr;
              r_bus_wdata <= mem_wdata;
              r_bus_wen   <= mem_wen;
              r_bus_wstrb <= mem_wstrb;
              r_state     <= S_BUS_REQ;
            end
          end
        end
        S_CLINT_RESP: r_state <= S_IDLE;
        S_BUS_REQ: begin
          if (bus_req_ready) r_state <= S_BUS_WAIT;
        end
        S_BUS_WAIT: begin
          if (bus_resp_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_ready  = w_idle;
  assign mem_resp_valid = w_clint_resp || w_bus_resp;
  assign mem_rdata      = w_bus_resp ? bus_rdata : (w_clint_resp ? r_resp : '0);

  assign cmp_ren   = w_cmp_hs;
  assign cmp_addr  = w_cmp_hs ? w_aligned : '0;
  assign cmp_wen   = w_cmp_wr;
  assign cmp_wdata = w_cmp_wr ? w_merged : '0;

  assign bus_req_valid = (r_state == S_BUS_REQ) && !rst;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;
  assign bus_wen       = r_bus_wen;
  assign bus_wstrb     = r_bus_wstrb;

endmodule

// File: tb/tb_ysyx_210247_mmio_router.sv
// Bench for the MMIO router: CLINT stub with mtime/mtimecmp, scripted bus target,
// and a byte-lane model of mtimecmp used to predict every response.
module tb_ysyx_210247_mmio_router;

  localparam logic [63:0] MTC   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] MTIME = 64'h0000_0000_0200_BFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        cmp_ren, cmp_wen;
  logic [63:0] cmp_addr, cmp_wdata, cmp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_wen, bus_resp_valid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  logic [63:0] tb_mtimecmp, tb_mtime;
  logic [63:0] ref_cmp;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_210247_mmio_router #(
    .CLINT_BASE   (64'h0000_0000_0200_0000),
    .CLINT_MASK   (64'hFFFF_FFFF_FFFF_0000),
    .MTIMECMP_ADDR(MTC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .cmp_ren(cmp_ren), .cmp_addr(cmp_addr), .cmp_wen(cmp_wen),
    .cmp_wdata(cmp_wdata), .cmp_rdata(cmp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  // CLINT stub: combinational read, mtime free-running, write on cmp_wen.
  always_comb begin
    cmp_rdata = '0;
    if (cmp_ren) begin
      if (cmp_addr == MTC) cmp_rdata = tb_mtimecmp;
      else if (cmp_addr == MTIME) cmp_rdata = tb_mtime;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tb_mtimecmp <= 64'd700000;
      tb_mtime    <= '0;
    end else begin
      tb_mtime <= tb_mtime + 64'd1;
      if (cmp_wen && cmp_addr == MTC) tb_mtimecmp <= cmp_wdata;
      if (cmp_wen && cmp_addr == MTIME) tb_mtime <= cmp_wdata;
    end
  end

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic is_clint(input logic [63:0] a);
    return (a >= 64'h0200_0000) && (a <= 64'h0200_FFFF);
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clint_access(input string nm, input logic [63:0] addr, input logic wen,
                              input logic [63:0] wd, input logic [7:0] ws);
    logic [63:0] al, exp_rd, exp_wd;
    logic hitw;
    al     = addr & ~64'h7;
    hitw   = wen && (al == MTC);
    exp_wd = hitw ? merge(ref_cmp, wd, ws) : 64'h0;
    mem_req_valid = 1'b1; mem_addr = addr; mem_wen = wen; mem_wdata = wd; mem_wstrb = ws;
    #1;
    exp_rd = wen ? 64'h0 : (al == MTC) ? ref_cmp : (al == MTIME) ? tb_mtime : 64'h0;
    checks++; if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL %s.ready got=%b exp=1", nm, mem_req_ready); end
    checks++; if (cmp_ren !== 1'b1) begin failures++; $display("FAIL %s.cmp_ren got=%b exp=1", nm, cmp_ren); end
    checks++; if (cmp_addr !== al) begin failures++; $display("FAIL %s.cmp_addr got=%h exp=%h", nm, cmp_addr, al); end
    checks++; if (cmp_wen !== hitw) begin failures++; $display("FAIL %s.cmp_wen got=%b exp=%b", nm, cmp_wen, hitw); end
    checks++; if (cmp_wdata !== exp_wd) begin failures++; $display("FAIL %s.cmp_wdata got=%h exp=%h", nm, cmp_wdata, exp_wd); end
    checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL %s.bus_valid got=%b exp=0", nm, bus_req_valid); end
    @(posedge clk);
    if (hitw) ref_cmp = exp_wd;
    @(negedge clk);
    mem_req_valid = 1'b0; mem_addr = {$urandom, $urandom};
    #1;
    checks++; if (mem_resp_valid !== 1'b1) begin failures++; $display("FAIL %s.resp_valid got=%b exp=1", nm, mem_resp_valid); end
    checks++; if (mem_rdata !== exp_rd) begin failures++; $display("FAIL %s.rdata got=%h exp=%h", nm, mem_rdata, exp_rd); end
    checks++; if (mem_req_ready !== 1'b0) begin failures++; $display("FAIL %s.ready_resp got=%b exp=0", nm, mem_req_ready); end
    checks++; if (cmp_ren !== 1'b0 || cmp_wen !== 1'b0) begin failures++; $display("FAIL %s.cmp_idle got=%b%b exp=00", nm, cmp_ren, cmp_wen); end
    tick();
    checks++; if (mem_resp_valid !== 1'b0 || mem_req_ready !== 1'b1) begin failures++; $display("FAIL %s.after got=%b%b exp=01", nm, mem_resp_valid, mem_req_ready); end
  endtask

  task automatic bus_access(input string nm, input logic [63:0] addr, input logic wen,
                            input logic [63:0] wd, input logic [7:0] ws, input int rdy_dly,
                            input int rsp_dly, input logic [63:0] rd, input logic glitch);
    mem_req_valid = 1'b1; mem_addr = addr; mem_wen = wen; mem_wdata = wd; mem_wstrb = ws;
    #1;
    checks++; if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL %s.ready got=%b exp=1", nm, mem_req_ready); end
    checks++; if (cmp_ren !== 1'b0 || bus_req_valid !== 1'b0) begin failures++; $display("FAIL %s.accept got=%b%b exp=00", nm, cmp_ren, bus_req_valid); end
    tick();
    mem_req_valid = 1'b0; mem_addr = ~addr; mem_wdata = ~wd; mem_wen = ~wen; mem_wstrb = ~ws;
    for (int k = 0; k <= rdy_dly; k++) begin
      bus_req_ready = (k == rdy_dly);
      bus_resp_valid = glitch && (k % 2 == 0);
      bus_rdata = {$urandom, $urandom};
      #1;
      checks++; if (bus_req_valid !== 1'b1) begin failures++; $display("FAIL %s.bus_valid got=%b exp=1", nm, bus_req_valid); end
      checks++; if (bus_addr !== addr || bus_wdata !== wd) begin failures++; $display("FAIL %s.bus_fields got=%h/%h exp=%h/%h", nm, bus_addr, bus_wdata, addr, wd); end
      checks++; if (bus_wen !== wen || bus_wstrb !== ws) begin failures++; $display("FAIL %s.bus_ctl got=%b/%h exp=%b/%h", nm, bus_wen, bus_wstrb, wen, ws); end
      checks++; if (mem_resp_valid !== 1'b0 || mem_req_ready !== 1'b0) begin failures++; $display("FAIL %s.req_phase got=%b%b exp=00", nm, mem_resp_valid, mem_req_ready); end
      tick();
    end
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    for (int k = 0; k < rsp_dly; k++) begin
      #1;
      checks++; if (bus_req_valid !== 1'b0 || mem_resp_valid !== 1'b0) begin failures++; $display("FAIL %s.wait got=%b%b exp=00", nm, bus_req_valid, mem_resp_valid); end
      tick();
    end
    bus_resp_valid = 1'b1; bus_rdata = rd;
    #1;
    checks++; if (mem_resp_valid !== 1'b1) begin failures++; $display("FAIL %s.resp_valid got=%b exp=1", nm, mem_resp_valid); end
    checks++; if (mem_rdata !== rd) begin failures++; $display("FAIL %s.rdata got=%h exp=%h", nm, mem_rdata, rd); end
    tick();
    bus_resp_valid = 1'b0;
    #1;
    checks++; if (mem_resp_valid !== 1'b0 || mem_req_ready !== 1'b1) begin failures++; $display("FAIL %s.after got=%b%b exp=01", nm, mem_resp_valid, mem_req_ready); end
  endtask

  task automatic check_reset_outputs(input string nm, input logic exp_ready);
    checks++; if (mem_req_ready !== exp_ready) begin failures++; $display("FAIL %s.ready got=%b exp=%b", nm, mem_req_ready, exp_ready); end
    checks++; if (mem_resp_valid !== 1'b0 || mem_rdata !== 64'h0) begin failures++; $display("FAIL %s.resp got=%b/%h exp=0/0", nm, mem_resp_valid, mem_rdata); end
    checks++; if (cmp_ren !== 1'b0 || cmp_wen !== 1'b0 || cmp_addr !== 64'h0 || cmp_wdata !== 64'h0) begin failures++; $display("FAIL %s.cmp got=%b%b/%h/%h exp=zero", nm, cmp_ren, cmp_wen, cmp_addr, cmp_wdata); end
    checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL %s.bus_valid got=%b exp=0", nm, bus_req_valid); end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_req_valid = 1'b1; mem_addr = MTC; mem_wen = 1'b0;
    mem_wdata = '0; mem_wstrb = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
    tick(); tick();
    #1;
    check_reset_outputs("reset_during", 1'b0);
    mem_req_valid = 1'b0;
    tick();
    rst = 1'b0; ref_cmp = 64'd700000;
    #1;
    check_reset_outputs("reset_after", 1'b1);
    checks++; if (bus_addr !== 64'h0 || bus_wdata !== 64'h0 || bus_wen !== 1'b0 || bus_wstrb !== 8'h0) begin failures++; $display("FAIL reset_after.bus_fields got=%h/%h/%b/%h exp=zero", bus_addr, bus_wdata, bus_wen, bus_wstrb); end
    tick();
  endtask

  task automatic test_clint;
    clint_access("cmp_read0", MTC, 1'b0, 64'h0, 8'h00);
    clint_access("cmp_wr_b0", MTC, 1'b1, 64'hFF, 8'h01);
    checks++; if (tb_mtimecmp !== 64'hAAEFF) begin failures++; $display("FAIL cmp_wr_b0.stored got=%h exp=00000000000aaeff", tb_mtimecmp); end
    clint_access("cmp_read1", MTC, 1'b0, 64'h0, 8'h00);
    clint_access("cmp_unaligned", MTC | 64'h5, 1'b0, 64'h0, 8'h00);
    clint_access("mtime_wr", MTIME, 1'b1, 64'h1234, 8'hFF);
    clint_access("mtime_rd0", MTIME, 1'b0, 64'h0, 8'h00);
    clint_access("mtime_rd1", MTIME, 1'b0, 64'h0, 8'h00);
    checks++; if (tb_mtime < 64'd8) begin failures++; $display("FAIL mtime_count got=%h exp=>=8", tb_mtime); end
    clint_access("cmp_next_wr", MTC + 64'h8, 1'b1, 64'hFFFF, 8'hFF);
    clint_access("msip_rd", 64'h0200_0000, 1'b0, 64'h0, 8'h00);
    clint_access("cmp_wr_hi", MTC, 1'b1, 64'h1122_3344_5566_7788, 8'hF0);
  endtask

  task automatic test_bus;
    bus_access("bus_rd", 64'h8000_0000, 1'b0, 64'h0, 8'h00, 3, 2, 64'hDEAD_BEEF, 1'b1);
    bus_access("bus_wr", 64'h8000_1008, 1'b1, 64'hCAFE_F00D_1234_5678, 8'h0F, 0, 0, 64'h55, 1'b0);
    bus_access("bus_above", 64'h0201_0000, 1'b0, 64'h0, 8'h00, 1, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
    bus_access("bus_below", 64'h01FF_FFF8, 1'b0, 64'h0, 8'h00, 0, 3, 64'hFEED, 1'b1);
    bus_access("bus_hi", 64'h1_0200_4000, 1'b0, 64'h0, 8'h00, 2, 0, 64'h77, 1'b0);
  endtask

  task automatic test_rst_mid;
    mem_req_valid = 1'b1; mem_addr = 64'h8000_0040; mem_wen = 1'b1;
    mem_wdata = 64'hABCD; mem_wstrb = 8'h3C; bus_req_ready = 1'b1;
    tick();
    mem_req_valid = 1'b0;
    tick();
    bus_req_ready = 1'b0; rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait_during", 1'b0);
    tick();
    rst = 1'b0; ref_cmp = 64'd700000;
    #1;
    check_reset_outputs("rst_wait_after", 1'b1);
    checks++; if (bus_addr !== 64'h0 || bus_wdata !== 64'h0 || bus_wen !== 1'b0 || bus_wstrb !== 8'h0) begin failures++; $display("FAIL rst_wait_after.bus_fields got=%h/%h/%b/%h exp=zero", bus_addr, bus_wdata, bus_wen, bus_wstrb); end
    tick();
    clint_access("rst_wait_read", MTC, 1'b0, 64'h0, 8'h00);
    mem_req_valid = 1'b1; mem_addr = MTC; mem_wen = 1'b0;
    tick();
    mem_req_valid = 1'b0; rst = 1'b1;
    #1;
    check_reset_outputs("rst_clint_resp", 1'b0);
    tick();
    rst = 1'b0; ref_cmp = 64'd700000;
    #1;
    check_reset_outputs("rst_clint_after", 1'b1);
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_ready;
    mem_req_valid = 1'b1; mem_addr = MTC; mem_wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_ready = (i % 2 == 0);
      #1;
      checks++; if (mem_req_ready !== exp_ready || mem_resp_valid !== !exp_ready) begin failures++; $display("FAIL b2b[%0d] got=%b%b exp=%b%b", i, mem_req_ready, mem_resp_valid, exp_ready, !exp_ready); end
      if (!exp_ready) begin
        checks++; if (mem_rdata !== ref_cmp) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, mem_rdata, ref_cmp); end
      end
      tick();
    end
    mem_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [63:0] a, d;
    for (int n = 0; n < 60; n++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: clint_access("rnd_cmp_wr", MTC | 64'($urandom_range(0, 7)), 1'b1, d, 8'($urandom));
        1: clint_access("rnd_cmp_rd", MTC, 1'b0, 64'h0, 8'h00);
        2: clint_access("rnd_mtime_rd", MTIME, 1'b0, 64'h0, 8'h00);
        3: begin
          a = 64'h0200_0000 | 64'($urandom_range(0, 16'hFFFF));
          if ((a & ~64'h7) == MTC) a = MTIME;
          clint_access("rnd_clint_wr", a, 1'b1, d, 8'($urandom));
        end
        4: clint_access("rnd_clint_rd", 64'h0200_0000 | 64'($urandom_range(0, 16'hFFFF)), 1'b0, 64'h0, 8'h00);
        default: begin
          a = {$urandom, $urandom};
          if (is_clint(a)) a[33] = ~a[33];
          bus_access("rnd_bus", a, 1'($urandom), d, 8'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), {$urandom, $urandom}, 1'($urandom));
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_clint();
    test_bus();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
